// File: rtl/rw_arbiter.sv
// Round-robin arbiter granting N requesters access to one shared read/write
// resource. One transaction at a time, with an acknowledge timeout.
module rw_arbiter #(
  parameter int N       = 4,
  parameter int TIMEOUT = 16
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic [N-1:0] req_i,
  input  logic [N-1:0] we_i,
  output logic [N-1:0] gnt_o,
  output logic [N-1:0] done_o,
  output logic         err_o,
  output logic         m_req,
  output logic         m_we,
  input  logic         m_ack,
  output logic         idle,
  output logic         read,
  output logic         write
);

  localparam int PW = $clog2(N);
  localparam int CW = $clog2(TIMEOUT);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_READ  = 2'd1;
  localparam logic [1:0] S_WRITE = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [N-1:0]  gnt_q, gnt_d;
  logic [N-1:0]  done_q, done_d;
  logic          err_q, err_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [PW-1:0] ptr_q, ptr_d;
  logic [PW-1:0] owner_q, owner_d;

  logic          win_valid;
  logic [PW-1:0] win_idx;

  // Search starts one past the last owner so a finished requester goes last.
  always_comb begin
    win_valid = 1'b0;
    win_idx   = '0;
    for (int k = 1; k <= N; k++) begin
      if (!win_valid && req_i[(int'(ptr_q) + k) % N]) begin
        win_valid = 1'b1;
        win_idx   = PW'((int'(ptr_q) + k) % N);
      end
    end
  end

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    done_d  = '0;
    err_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (win_valid) begin
          gnt_d          = '0;
          gnt_d[win_idx] = 1'b1;
          owner_d        = win_idx;
          cnt_d          = '0;
          state_d        = we_i[win_idx] ? S_WRITE : S_READ;
        end
      end
      S_READ, S_WRITE: begin
        if (m_ack || cnt_q == CW'(TIMEOUT - 1)) begin
          // An ack arriving on the timeout edge still counts as a clean finish.
          state_d = S_IDLE;
          gnt_d   = '0;
          ptr_d   = owner_q;
          done_d  = gnt_q;
          err_d   = !m_ack;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      gnt_q   <= '0;
      done_q  <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
      ptr_q   <= PW'(N - 1);
      owner_q <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
    end
  end

  assign gnt_o  = gnt_q;
  assign done_o = done_q;
  assign err_o  = err_q;
  assign idle   = (state_q == S_IDLE);
  assign read   = (state_q == S_READ);
  assign write  = (state_q == S_WRITE);
  assign m_req  = read | write;
  assign m_we   = write;

endmodule

// File: tb/tb_rw_arbiter.sv
// Self-checking bench for rw_arbiter: directed scenarios plus randomized traffic
// against a transaction-level round-robin model feeding a scoreboard.
module tb_rw_arbiter;

  localparam int N       = 4;
  localparam int TIMEOUT = 16;

  logic         clk = 1'b0;
  logic         resetn = 1'b0;
  logic [N-1:0] req_v = '0;
  logic [N-1:0] we_v = '0;
  logic         ack_v = 1'b0;
  logic [N-1:0] gnt_o, done_o;
  logic         err_o, m_req, m_we, idle, read, write;

  rw_arbiter #(.N(N), .TIMEOUT(TIMEOUT)) dut (
    .clk    (clk),
    .resetn (resetn),
    .req_i  (req_v),
    .we_i   (we_v),
    .gnt_o  (gnt_o),
    .done_o (done_o),
    .err_o  (err_o),
    .m_req  (m_req),
    .m_we   (m_we),
    .m_ack  (ack_v),
    .idle   (idle),
    .read   (read),
    .write  (write)
  );

  always #5 clk = ~clk;

  typedef struct { int idx; bit we; } grant_t;
  typedef struct { logic [N-1:0] done; bit err; } comp_t;

  grant_t grant_q[$];
  comp_t  comp_q[$];

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Reference model: one transaction at a time, round-robin from last owner + 1.
  bit m_busy = 1'b0;
  bit m_we_exp = 1'b0;
  int m_owner = 0;
  int m_wait = 0;
  int m_ptr = N - 1;

  task automatic model_complete(input bit err);
    comp_t c;
    c.done = '0;
    c.done[m_owner] = 1'b1;
    c.err = err;
    comp_q.push_back(c);
    m_busy = 1'b0;
    m_ptr = m_owner;
  endtask

  initial begin
    forever begin
      @(posedge clk);
      if (!resetn) begin
        m_busy = 1'b0;
        m_ptr = N - 1;
        grant_q.delete();
        comp_q.delete();
      end else if (!m_busy) begin
        if (req_v != '0) begin
          grant_t g;
          int w;
          w = -1;
          for (int k = 1; k <= N; k++)
            if (w < 0 && req_v[(m_ptr + k) % N]) w = (m_ptr + k) % N;
          m_busy = 1'b1;
          m_owner = w;
          m_we_exp = we_v[w];
          m_wait = 0;
          g.idx = w;
          g.we = we_v[w];
          grant_q.push_back(g);
        end
      end else begin
        m_wait++;
        if (ack_v) model_complete(1'b0);
        else if (m_wait == TIMEOUT) model_complete(1'b1);
      end
    end
  end

  // Monitor: compares DUT status every cycle and pops the scoreboard on grant/done.
  logic [N-1:0] prev_gnt = '0;
  grant_t       mon_g;
  comp_t        mon_c;

  initial begin
    forever begin
      @(negedge clk);
      if (!resetn) begin
        prev_gnt = '0;
      end else begin
        check("state", {idle, read, write}, {!m_busy, m_busy && !m_we_exp, m_busy && m_we_exp});
        check("m_req_m_we", {m_req, m_we}, {m_busy, m_busy && m_we_exp});
        if (gnt_o != '0 && prev_gnt == '0) begin
          if (grant_q.size() == 0) check("grant_unexpected", gnt_o, 0);
          else begin
            mon_g = grant_q.pop_front();
            check("grant", gnt_o, 32'd1 << mon_g.idx);
            check("grant_we", m_we, mon_g.we);
          end
        end
        if (done_o != '0 || err_o) begin
          if (comp_q.size() == 0) check("done_unexpected", {err_o, done_o}, 0);
          else begin
            mon_c = comp_q.pop_front();
            check("done_err", {err_o, done_o}, {mon_c.err, mon_c.done});
          end
        end
        prev_gnt = gnt_o;
      end
    end
  end

  task automatic wait_gnt(input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (gnt_o != '0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check({name, "_grant_timeout"}, 0, 1);
  endtask

  task automatic pulse_reset();
    resetn = 1'b0;
    req_v = '0;
    ack_v = 1'b0;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
  endtask

  initial begin
    int  cnt;
    bit  seen;

    repeat (3) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    check("rst_state", {idle, read, write}, 3'b100);
    check("rst_m_req_we", {m_req, m_we}, 2'b00);
    check("rst_gnt", gnt_o, 0);
    check("rst_done_err", {err_o, done_o}, 0);

    // Single read by requester 0, acknowledged three cycles after the request.
    req_v = 4'b0001;
    we_v = 4'b0000;
    @(negedge clk);
    check("rd_state", {idle, read, write}, 3'b010);
    check("rd_m_req_we", {m_req, m_we}, 2'b10);
    check("rd_gnt", gnt_o, 4'b0001);
    @(negedge clk);
    @(negedge clk);
    ack_v = 1'b1;
    @(negedge clk);
    check("rd_done", {err_o, done_o}, 5'b00001);
    check("rd_idle", idle, 1);
    req_v = '0;
    ack_v = 1'b0;
    @(negedge clk);
    check("rd_done_one_cycle", done_o, 0);

    // All four requesting: rotation 0,1,2,3,0 with writes only for 1 and 3.
    pulse_reset();
    req_v = 4'b1111;
    we_v = 4'b1010;
    for (int k = 0; k < 5; k++) begin
      wait_gnt("rr");
      check($sformatf("rr_gnt%0d", k), gnt_o, 32'd1 << (k % 4));
      check($sformatf("rr_write%0d", k), write, k % 2);
      ack_v = 1'b1;
      @(negedge clk);
      ack_v = 1'b0;
      check($sformatf("rr_done%0d", k), done_o, 32'd1 << (k % 4));
    end
    req_v = '0;
    @(negedge clk);

    // Write by requester 2 never acknowledged: TIMEOUT cycles in WRITE, then error.
    req_v = 4'b0100;
    we_v = 4'b0100;
    cnt = 0;
    seen = 1'b0;
    for (int i = 0; i < TIMEOUT + 5; i++) begin
      @(negedge clk);
      if (err_o || done_o != '0) begin
        seen = 1'b1;
        break;
      end
      if (write) cnt++;
    end
    check("to_seen", seen, 1);
    check("to_write_cycles", cnt, TIMEOUT);
    check("to_err_done", {err_o, done_o}, 5'b10100);
    check("to_idle", idle, 1);
    req_v = '0;
    @(negedge clk);
    check("to_pulse_one_cycle", {err_o, done_o}, 0);

    // Ack arriving on the timeout edge wins: clean completion, no error.
    req_v = 4'b0100;
    cnt = 0;
    seen = 1'b0;
    for (int i = 0; i < TIMEOUT + 5; i++) begin
      @(negedge clk);
      if (err_o || done_o != '0) begin
        seen = 1'b1;
        break;
      end
      if (write) cnt++;
      if (cnt == TIMEOUT) ack_v = 1'b1;
    end
    check("to_ack_seen", seen, 1);
    check("to_ack_cycles", cnt, TIMEOUT);
    check("to_ack_err_done", {err_o, done_o}, 5'b00100);
    req_v = '0;
    ack_v = 1'b0;
    @(negedge clk);

    // Reset mid-read for requester 2, then 0 and 2 compete: 0 wins.
    req_v = 4'b0100;
    we_v = 4'b0000;
    wait_gnt("mid_rst");
    check("mid_rst_read", {read, gnt_o}, {1'b1, 4'b0100});
    @(negedge clk);
    resetn = 1'b0;
    #1;
    check("mid_rst_state", {idle, read, write}, 3'b100);
    check("mid_rst_outputs", {gnt_o, done_o, err_o, m_req}, 0);
    @(negedge clk);
    check("mid_rst_no_done", {err_o, done_o}, 0);
    resetn = 1'b1;
    req_v = 4'b0101;
    wait_gnt("post_rst");
    check("post_rst_prio", gnt_o, 4'b0001);
    ack_v = 1'b1;
    @(negedge clk);
    ack_v = 1'b0;
    req_v = 4'b0100;
    wait_gnt("post_rst2");
    check("post_rst_next", gnt_o, 4'b0100);
    ack_v = 1'b1;
    @(negedge clk);
    ack_v = 1'b0;
    req_v = '0;

    // Ack held high while idle with no requests does nothing.
    ack_v = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("idle_ack_ignored", {idle, done_o, err_o}, {1'b1, 4'b0000, 1'b0});
    end
    ack_v = 1'b0;

    // Randomized traffic, including changing we_i and occasional resets.
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
        if (done_o[i]) req_v[i] = 1'b0;
        else if (!req_v[i] && $urandom_range(0, 3) == 0) req_v[i] = 1'b1;
      end
      we_v = N'($urandom);
      ack_v = ($urandom_range(0, 7) == 0);
      if (!resetn) resetn = 1'b1;
      else if ($urandom_range(0, 599) == 0) resetn = 1'b0;
    end
    resetn = 1'b1;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      for (int j = 0; j < N; j++) if (done_o[j]) req_v[j] = 1'b0;
      ack_v = ($urandom_range(0, 3) == 0);
      if (req_v == '0 && !m_busy) break;
    end
    ack_v = 1'b0;
    repeat (3) @(negedge clk);
    check("drain_requests", req_v, 0);
    check("scoreboard_drained", grant_q.size() + comp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/rw_arbiter.md
RW_ARBITER -- requirements
Module: rw_arbiter

Interface
REQ-001 Parameter N, 4, number of requesters sharing one read/write resource (2..8).
REQ-002 Parameter TIMEOUT, 16, max cycles waited for m_ack per transaction (>=2).
REQ-003 clk  input  1  single clock, all state updates on rising edge.
REQ-004 resetn  input  1  reset, asynchronous, active-low.
REQ-005 req_i  input  N  per-requester transaction request, level, held until done_o.
REQ-006 we_i  input  N  per-requester direction: 1 = write, 0 = read, sampled at grant.
REQ-007 gnt_o  output  N  one-hot grant, identifies requester owning the resource.
REQ-008 done_o  output  N  one-cycle completion pulse to the owning requester.
REQ-009 err_o  output  1  one-cycle pulse, transaction ended by timeout.
REQ-010 m_req  output  1  request to shared resource.
REQ-011 m_we  output  1  write enable to shared resource.
REQ-012 m_ack  input  1  completion acknowledge from shared resource.
REQ-013 idle, read, write  output  1 each  one-hot state status.

Function
REQ-014 Moore FSM, states IDLE, READ, WRITE; idle/read/write SHALL be 1 exactly in the matching state.
REQ-015 gnt_o, m_req, m_we, idle, read, write SHALL be registered or decoded from registered state only, with no combinational path from any input.
REQ-016 IDLE, any req_i bit set at edge t: winner SHALL be chosen round-robin, searching from index ptr+1 upward with wrap at N-1 -> 0.
REQ-017 On that edge: gnt_o = one-hot(winner), latched_we = we_i[winner], next state WRITE if latched_we else READ.
REQ-018 Grant latency SHALL be 1 cycle: req_i sampled high in IDLE -> m_req high in the following cycle.
REQ-019 READ/WRITE: m_req = 1, m_we = latched_we; gnt_o held constant.
REQ-020 Changes to req_i or we_i during READ/WRITE SHALL NOT affect the transaction in progress.
REQ-021 m_ack = 1 at edge in READ/WRITE: next state IDLE, gnt_o = 0, ptr = winner, done_o[winner] = 1 for exactly one cycle.
REQ-022 m_ack SHALL be ignored in IDLE.
REQ-023 Wait counter SHALL clear on entry to READ/WRITE and increment each cycle in READ/WRITE without m_ack.
REQ-024 Counter reaching TIMEOUT-1 without m_ack: next state IDLE, ptr = winner, done_o[winner] = 1 and err_o = 1 for one cycle.
REQ-025 m_ack on the timeout edge SHALL take priority: normal completion, err_o = 0.
REQ-026 After every completion the FSM SHALL spend at least one cycle in IDLE, giving a peak rate of one transaction per 2 cycles.
REQ-027 A requester holding req_i after done_o SHALL NOT win again while any other req_i bit is set at the arbitration edge.
REQ-028 Counter width SHALL be ceil(log2(TIMEOUT)) bits and SHALL NOT wrap.

Reset
REQ-029 resetn = 0 SHALL, asynchronously: state = IDLE, idle = 1, read = write = 0, gnt_o = 0, done_o = 0, err_o = 0, m_req = m_we = 0, counter = 0, ptr = N-1.
REQ-030 Reset asserted mid-transaction SHALL abort the transaction with no done_o or err_o pulse.
REQ-031 After reset, requester 0 SHALL have highest priority at the first arbitration.

Verification
REQ-032 Reset release, req_i = 0 -> idle/read/write = 100, m_req = 0, gnt_o = 0000.
REQ-033 req_i = 0001, we_i = 0, m_ack asserted 3 cycles later -> read = 1, m_req = 1, m_we = 0, gnt_o = 0001 the cycle after request; done_o = 0001 one cycle; idle = 1.
REQ-034 req_i = 1111, we_i = 1010, ack each transaction after 1 cycle -> grant order 0,1,2,3,0; write = 1 only for requesters 1 and 3.
REQ-035 req_i = 0100, we_i = 0100, m_ack never asserted -> after TIMEOUT cycles in WRITE: err_o = 1, done_o = 0100 for one cycle, state IDLE.
REQ-036 resetn pulsed low during READ for requester 2 -> immediate idle = 1, gnt_o = 0, no done_o; next request from 0 and 2 together -> 0 wins.
REQ-037 m_ack held high while in IDLE with req_i = 0 -> no state change, no done_o.
